// File: rtl/mips_fetch_pkg.sv
// Shared types and default constants for the MIPS instruction fetch unit.
package mips_fetch_pkg;

    typedef enum logic {
        RUN,
        HALT_MISALIGN
    } fetch_state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam logic [63:0] DEF_RESET_PC   = 64'h0000_0000_0000_0000;
    localparam logic [63:0] DEF_EXC_VECTOR = 64'h0000_0000_8000_0180;

endpackage

// File: rtl/mips_fetch_fifo.sv
// Small synchronous FIFO of fetch entries with push, pop, flush and occupancy count.
module mips_fetch_fifo
    import mips_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  din,
    output fetch_entry_t  dout,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // a push into a full FIFO is only accepted when the head leaves the same cycle
    assign rd_en = pop && (count != '0);
    assign wr_en = push && ((count != CW'(DEPTH)) || rd_en);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= bump(wr_ptr);
            if (rd_en) rd_ptr <= bump(rd_ptr);
            count <= count + CW'(wr_en) - CW'(rd_en);
        end
    end

    always_ff @(posedge clock) begin
        if (reset && !flush && wr_en) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction fetch: owns the PC, issues imem requests, queues returned words
// for decode and handles redirects, exceptions and misaligned targets.
module mips_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC        = DEF_RESET_PC,
    parameter logic [63:0] EXC_VECTOR      = DEF_EXC_VECTOR,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        except_req,
    output logic        fetch_misaligned
);

    fetch_state_t state, state_nxt;
    logic [63:0]  pc, pc_nxt;
    logic [1:0]   drop_cnt, drop_nxt;
    logic [1:0]   outstanding;
    logic [1:0]   q_count;
    fetch_entry_t shadow_din, shadow_head;
    fetch_entry_t q_din, q_head;
    logic         ctrl;
    logic         req_fire;
    logic         resp_fire;
    logic         resp_drop;
    logic         q_push;
    logic         q_pop;

    assign ctrl = except_req || redirect_valid;

    assign imem_req_valid = reset && (state == RUN) && !ctrl &&
                            (({1'b0, outstanding} + {1'b0, q_count}) < 3'(MAX_OUTSTANDING));
    assign imem_addr      = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // a response with nothing in flight is a protocol error and is ignored
    assign resp_fire = imem_resp_valid && (outstanding != 2'd0);
    assign resp_drop = resp_fire && (drop_cnt != 2'd0);
    assign q_push    = resp_fire && !resp_drop && !ctrl;
    assign q_pop     = inst_valid && inst_ready;

    // PC of every in-flight request, in issue order; its occupancy is the in-flight count
    assign shadow_din = '{pc: pc, inst: 32'd0};

    mips_fetch_fifo #(.DEPTH(2)) u_shadow (
        .clock (clock),
        .reset (reset),
        .push  (req_fire),
        .pop   (resp_fire),
        .flush (1'b0),
        .din   (shadow_din),
        .dout  (shadow_head),
        .count (outstanding)
    );

    always_comb begin
        q_din      = shadow_head;
        q_din.inst = imem_resp_data;
    end

    mips_fetch_fifo #(.DEPTH(2)) u_queue (
        .clock (clock),
        .reset (reset),
        .push  (q_push),
        .pop   (q_pop),
        .flush (ctrl),
        .din   (q_din),
        .dout  (q_head),
        .count (q_count)
    );

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        drop_nxt  = drop_cnt;
        if (resp_drop) drop_nxt = drop_cnt - 2'd1;
        if (req_fire)  pc_nxt   = pc + 64'd4;
        // every response still in flight after a control transfer is stale; the
        // in-flight count already covers drops that were pending before
        if (except_req) begin
            state_nxt = RUN;
            pc_nxt    = EXC_VECTOR;
            drop_nxt  = outstanding - {1'b0, resp_fire};
        end else if (redirect_valid) begin
            state_nxt = (redirect_pc[1:0] != 2'b00) ? HALT_MISALIGN : RUN;
            pc_nxt    = redirect_pc;
            drop_nxt  = outstanding - {1'b0, resp_fire};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= RUN;
            pc       <= RESET_PC;
            drop_cnt <= 2'd0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            drop_cnt <= drop_nxt;
        end
    end

    assign inst_valid       = (q_count != 2'd0);
    assign inst             = inst_valid ? q_head.inst : 32'd0;
    assign inst_pc          = inst_valid ? q_head.pc : 64'd0;
    assign fetch_misaligned = (state == HALT_MISALIGN);

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Scoreboard bench for mips_fetch_unit: directed phases feed an expected-word
// queue, a monitor checks every word decode consumes, a model memory answers requests.
module tb_mips_fetch_unit;

    localparam logic [63:0] EXC = 64'h0000_0000_8000_0180;

    logic        clock;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        except_req;
    logic        fetch_misaligned;

    int tests = 0;
    int fails = 0;
    int cyc_cnt = 0;
    int first_acc_cyc = -1;
    int first_valid_cyc = -1;
    logic mem_hold;
    logic [95:0] sb [$];
    logic [63:0] pend [$];

    mips_fetch_unit #(
        .RESET_PC        (64'h0),
        .EXC_VECTOR      (EXC),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .imem_req_valid   (imem_req_valid),
        .imem_req_ready   (imem_req_ready),
        .imem_addr        (imem_addr),
        .imem_resp_valid  (imem_resp_valid),
        .imem_resp_data   (imem_resp_data),
        .inst_valid       (inst_valid),
        .inst_ready       (inst_ready),
        .inst             (inst),
        .inst_pc          (inst_pc),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .except_req       (except_req),
        .fetch_misaligned (fetch_misaligned)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

    function automatic logic [31:0] word_of(input logic [63:0] a);
        return 32'hA0 + a[33:2];
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_at(input logic [63:0] a);
        sb.push_back({a, word_of(a)});
    endtask

    // hold imem_req_ready high until exactly n requests have been accepted
    task automatic grant(input int n);
        int got = 0;
        int cycles = 0;
        imem_req_ready = 1'b1;
        while (got < n && cycles < 100) begin
            @(negedge clock);
            if (reset && imem_req_valid && imem_req_ready) begin
                if (got == 0) first_acc_cyc = cyc_cnt;
                got++;
            end
            step();
            cycles++;
        end
        imem_req_ready = 1'b0;
        check("grant_count", got, n);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            step();
            n++;
        end
        check({name, "_drained"}, sb.size(), 0);
        repeat (2) step();
        @(negedge clock);
        check({name, "_idle"}, inst_valid, 1'b0);
        step();
    endtask

    // model memory: answers one cycle after acceptance, in order, unless held
    initial begin
        logic        acc, h, r;
        logic [63:0] a;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'd0;
        forever begin
            @(negedge clock);
            acc = reset && imem_req_valid && imem_req_ready;
            a   = imem_addr;
            h   = mem_hold;
            r   = reset;
            step();
            if (!r) begin
                pend.delete();
            end else begin
                if (imem_resp_valid) void'(pend.pop_front());
                if (acc) pend.push_back(a);
            end
            if (r && !h && pend.size() > 0) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = word_of(pend[0]);
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = 32'd0;
            end
        end
    end

    // monitor: every word decode takes must be the next one expected
    initial begin
        logic [95:0] e;
        forever begin
            @(negedge clock);
            if (reset && inst_valid && first_valid_cyc < 0) first_valid_cyc = cyc_cnt;
            if (reset && inst_valid && inst_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_inst: got pc=%h inst=%h, required none", inst_pc, inst);
                end else begin
                    e = sb.pop_front();
                    check("inst_stream", {inst_pc, inst}, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int acc;
        reset = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'd0;
        except_req = 1'b0; imem_req_ready = 1'b0; mem_hold = 1'b0;
        repeat (3) step();
        @(negedge clock);
        check("rst_req_valid", imem_req_valid, 1'b0);
        check("rst_inst_valid", inst_valid, 1'b0);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_pc", inst_pc, 64'd0);
        check("rst_misaligned", fetch_misaligned, 1'b0);
        check("rst_addr", imem_addr, 64'd0);
        step();

        // sequential fetch from reset
        reset = 1'b1; inst_ready = 1'b1; first_valid_cyc = -1;
        for (int i = 0; i < 4; i++) expect_at(64'(i * 4));
        grant(4);
        drain("seq");
        check("first_valid_latency", first_valid_cyc - first_acc_cyc, 2);

        // decode stall: at most two words in flight or queued
        inst_ready = 1'b0; imem_req_ready = 1'b1; acc = 0;
        repeat (6) begin
            @(negedge clock);
            if (imem_req_valid && imem_req_ready) acc++;
            step();
        end
        imem_req_ready = 1'b0;
        @(negedge clock);
        check("stall_accepts", acc, 2);
        check("stall_req_blocked", imem_req_valid, 1'b0);
        check("stall_head_pc", inst_pc, 64'h10);
        check("stall_head_inst", inst, word_of(64'h10));
        step();
        expect_at(64'h10); expect_at(64'h14);
        inst_ready = 1'b1;
        drain("stall");

        // redirect with two requests still in flight
        mem_hold = 1'b1;
        grant(2);
        redirect_valid = 1'b1; redirect_pc = 64'h100;
        @(negedge clock);
        check("redir_no_issue", imem_req_valid, 1'b0);
        step();
        redirect_valid = 1'b0; mem_hold = 1'b0;
        @(negedge clock);
        check("redir_addr", imem_addr, 64'h100);
        step();
        expect_at(64'h100); expect_at(64'h104);
        grant(2);
        drain("redirect");

        // exception wins over a simultaneous redirect
        except_req = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h200;
        @(negedge clock);
        check("exc_no_issue", imem_req_valid, 1'b0);
        step();
        except_req = 1'b0; redirect_valid = 1'b0;
        @(negedge clock);
        check("exc_addr", imem_addr, EXC);
        step();
        expect_at(EXC);
        grant(1);
        drain("except");

        // misaligned target halts fetch until an aligned redirect
        redirect_valid = 1'b1; redirect_pc = 64'h102;
        step();
        redirect_valid = 1'b0; imem_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("halt_flag", fetch_misaligned, 1'b1);
            check("halt_no_issue", imem_req_valid, 1'b0);
            step();
        end
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 64'h300;
        step();
        redirect_valid = 1'b0;
        @(negedge clock);
        check("resume_flag", fetch_misaligned, 1'b0);
        check("resume_addr", imem_addr, 64'h300);
        step();
        expect_at(64'h300); expect_at(64'h304);
        grant(2);
        drain("resume");

        // reset with a full queue
        inst_ready = 1'b0; imem_req_ready = 1'b1;
        repeat (6) step();
        imem_req_ready = 1'b0;
        @(negedge clock);
        check("pre_rst_full", inst_valid, 1'b1);
        check("pre_rst_head", inst_pc, 64'h308);
        step();
        reset = 1'b0;
        @(negedge clock);
        check("mid_rst_req_valid", imem_req_valid, 1'b0);
        step();
        reset = 1'b1; inst_ready = 1'b1;
        @(negedge clock);
        check("post_rst_inst_valid", inst_valid, 1'b0);
        check("post_rst_inst", inst, 32'd0);
        check("post_rst_addr", imem_addr, 64'd0);
        step();
        expect_at(64'h0); expect_at(64'h4);
        grant(2);
        drain("restart");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
